serial_tx_scheduler: RTL and testbench

- Upstream arbiter and frame generator for the multi-channel serial transmitter.
- Up to four requesters each post a payload, a bit-length and a destination port.
- The block grants one requester at a time in round-robin order.
- It drives the transmitter's serial input with a start bit, a 2-bit port id, a length field and the payload bits.
- It then waits for the transmitter's done before starting the next frame.

---
 rtl/serial_tx_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_serial_tx_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler
//   Round-robin arbiter and frame generator in front of the multi-channel
//   serial transmitter. Up to four requesters post a payload, a bit length
//   and a port id. One requester is granted at a time. Its frame is sent on
//   ser_out as: start bit (0), 2-bit port id MSB first, LEN_W-bit length
//   MSB first, then L payload bits LSB first. The block then waits for
//   tx_done, or for a timeout of TMO cycles, before serving the next request.
//
//   Optional feature, selected by the macro PARITY_EN:
//     defined   - one even-parity bit (XOR of id, length and payload bits)
//                 is sent after the payload, before WAIT_DONE.
//     undefined - the frame ends after the payload.
//
//   The port-id field is 2 bits, so NCH must stay at 4.
//   DATA_W must be at least 2**LEN_W-1.

module serial_tx_scheduler #(
  parameter int NCH    = 4,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 16,
  parameter int TMO    = 64
) (
  input  logic                  clk,
  input  logic                  rst,       // asynchronous, active low
  input  logic [NCH-1:0]        req,
  input  logic [NCH*LEN_W-1:0]  req_len,
  input  logic [NCH*DATA_W-1:0] req_data,
  input  logic                  tx_done,
  output logic [NCH-1:0]        grant,
  output logic                  ser_out,
  output logic                  busy,
  output logic [1:0]            cur_ch,
  output logic                  timeout
);

  // Width of the WAIT_DONE cycle counter: holds 0 .. TMO-1.
  localparam int TMO_W = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_START,
    ST_ID,
    ST_LEN,
    ST_DATA,
`ifdef PARITY_EN
    ST_PARITY,
`endif
    ST_WAIT
  } state_t;

  // State that follows the last payload bit (or the last length bit if L=0).
`ifdef PARITY_EN
  localparam state_t ST_AFTER_PAYLOAD = ST_PARITY;
`else
  localparam state_t ST_AFTER_PAYLOAD = ST_WAIT;
`endif

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t            r_state;
  logic [1:0]        r_ptr;       // round-robin search start
  logic [1:0]        r_cur_ch;    // id of the channel being served
  logic [LEN_W-1:0]  r_len;       // latched (clamped) payload length
  logic [LEN_W-1:0]  r_len_sh;    // length field, shifted out MSB first
  logic [LEN_W-1:0]  r_bit_cnt;   // down-counter for the ID/LEN/DATA fields
  logic [DATA_W-1:0] r_data;      // payload, shifted out LSB first
  logic [TMO_W-1:0]  r_wait_cnt;  // cycles spent in WAIT_DONE
  logic              r_timeout;
`ifdef PARITY_EN
  logic              r_parity;    // running XOR of id, length and payload bits
`endif

  // ---------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------
  state_t            w_state_next;
  logic              w_found;
  logic [1:0]        w_win;
  logic [LEN_W-1:0]  w_sel_len;
  logic [LEN_W-1:0]  w_len_clamped;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_cnt_zero;
  logic              w_wait_expired;
  logic              w_ser;

  // Round-robin search: first set req bit from r_ptr upward, wrapping 3->0.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && req[2'(r_ptr + 2'(k))]) begin
        w_found = 1'b1;
        w_win   = 2'(r_ptr + 2'(k));
      end
    end
  end

  // Slice the winner's length and payload; clamp the length to DATA_W.
  assign w_sel_len      = req_len[int'(w_win)*LEN_W +: LEN_W];
  assign w_sel_data     = req_data[int'(w_win)*DATA_W +: DATA_W];
  assign w_len_clamped  = (int'(w_sel_len) > DATA_W) ? LEN_W'(DATA_W) : w_sel_len;

  assign w_cnt_zero     = (r_bit_cnt == '0);
  assign w_wait_expired = (r_wait_cnt == TMO_W'(TMO - 1));

  // ---------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled before the edge.
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (|req) w_state_next = ST_ARB;
      // A request withdrawn during ARB returns to IDLE without a grant.
      ST_ARB:    w_state_next = w_found ? ST_START : ST_IDLE;
      ST_START:  w_state_next = ST_ID;
      ST_ID:     if (w_cnt_zero) w_state_next = ST_LEN;
      // A zero-length payload skips DATA entirely.
      ST_LEN:    if (w_cnt_zero) w_state_next = (r_len == '0) ? ST_AFTER_PAYLOAD : ST_DATA;
      ST_DATA:   if (w_cnt_zero) w_state_next = ST_AFTER_PAYLOAD;
`ifdef PARITY_EN
      ST_PARITY: w_state_next = ST_WAIT;
`endif
      ST_WAIT:   if (tx_done || w_wait_expired) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM process 3: outputs decoded from the current state
  // ---------------------------------------------------------------------
  always_comb begin
    w_ser = 1'b1;
    grant = '0;
    case (r_state)
      ST_ARB:    if (w_found) grant[w_win] = 1'b1;
      ST_START:  w_ser = 1'b0;
      // r_bit_cnt is 1 for the id MSB and 0 for the id LSB.
      ST_ID:     w_ser = r_bit_cnt[0] ? r_cur_ch[1] : r_cur_ch[0];
      ST_LEN:    w_ser = r_len_sh[LEN_W-1];
      ST_DATA:   w_ser = r_data[0];
`ifdef PARITY_EN
      ST_PARITY: w_ser = r_parity;
`endif
      default:   w_ser = 1'b1;
    endcase
  end

  assign ser_out = w_ser;
  assign busy    = (r_state != ST_IDLE);
  assign cur_ch  = r_cur_ch;
  assign timeout = r_timeout;

  // ---------------------------------------------------------------------
  // Datapath: latch the winner, step the field counters, shift the fields
  // out, time WAIT_DONE.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register here, including the latched payload, is cleared
    // by reset, so a frame cut short by reset cannot leak into a later one.
    if (!rst) begin
      r_ptr      <= '0;
      r_cur_ch   <= '0;
      r_len      <= '0;
      r_len_sh   <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
`ifdef PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
      case (r_state)
        ST_ARB: begin
          if (w_found) begin
            r_len    <= w_len_clamped;
            r_len_sh <= w_len_clamped;
            r_data   <= w_sel_data;
            r_cur_ch <= w_win;
            r_ptr    <= w_win + 2'd1;
          end
        end
        ST_START: begin
          r_bit_cnt <= LEN_W'(1);
`ifdef PARITY_EN
          r_parity  <= 1'b0;
`endif
        end
        ST_ID: begin
          r_bit_cnt <= w_cnt_zero ? LEN_W'(LEN_W - 1) : r_bit_cnt - LEN_W'(1);
`ifdef PARITY_EN
          r_parity  <= r_parity ^ w_ser;
`endif
        end
        ST_LEN: begin
          r_len_sh  <= r_len_sh << 1;
          // On the last length bit, load the payload count (unused if L=0).
          r_bit_cnt <= w_cnt_zero ? r_len - LEN_W'(1) : r_bit_cnt - LEN_W'(1);
`ifdef PARITY_EN
          r_parity  <= r_parity ^ w_ser;
`endif
        end
        ST_DATA: begin
          r_data <= r_data >> 1;
          if (!w_cnt_zero) begin
            r_bit_cnt <= r_bit_cnt - LEN_W'(1);
          end
`ifdef PARITY_EN
          r_parity <= r_parity ^ w_ser;
`endif
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + TMO_W'(1);
          // tx_done arriving on the last allowed cycle wins over the timeout.
          if (w_wait_expired && !tx_done) begin
            r_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Testbench for serial_tx_scheduler: table-driven single frames plus
// hand-written sequences for round-robin, timeout, reset mid-frame and a
// request withdrawn during arbitration. Expected frame bits and expected
// grants are produced by a small model and held in scoreboard queues.

module tb_serial_tx_scheduler;

  localparam int NCH    = 4;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 16;
  localparam int TMO    = 64;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH-1:0]        req;
  logic [NCH*LEN_W-1:0]  req_len;
  logic [NCH*DATA_W-1:0] req_data;
  logic                  tx_done;
  logic [NCH-1:0]        grant;
  logic                  ser_out;
  logic                  busy;
  logic [1:0]            cur_ch;
  logic                  timeout;

  int n_checks = 0;
  int n_errors = 0;

  bit         q_bits[$];   // expected ser_out bits of the frame in flight
  logic [3:0] q_grant[$];  // expected grant vectors, in order

  typedef struct {
    int          ch;
    int          len;
    logic [15:0] data;
    int          done_dly;   // WAIT_DONE cycles before tx_done
    int          glitch;     // frame bit index carrying a stray tx_done, -1 none
    logic [3:0]  exp_grant;
  } vec_t;

  vec_t vecs[7];

  serial_tx_scheduler #(
    .NCH(NCH), .LEN_W(LEN_W), .DATA_W(DATA_W), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
    .tx_done(tx_done), .grant(grant), .ser_out(ser_out), .busy(busy),
    .cur_ch(cur_ch), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int ch, input int len, input logic [15:0] data);
    req_len[ch*LEN_W +: LEN_W]    = LEN_W'(len);
    req_data[ch*DATA_W +: DATA_W] = data;
  endtask

  // Reference frame model: start, id MSB first, length MSB first, payload LSB first.
  task automatic push_frame(input int ch, input int len, input logic [15:0] data);
    int         l;
    logic [3:0] lv;
    logic [1:0] id;
    bit         p;
    l  = (len > DATA_W) ? DATA_W : len;
    lv = 4'(l);
    id = 2'(ch);
    p  = 1'b0;
    q_bits.push_back(1'b0);
    for (int i = 1; i >= 0; i--) begin q_bits.push_back(id[i]); p ^= id[i]; end
    for (int i = LEN_W - 1; i >= 0; i--) begin q_bits.push_back(lv[i]); p ^= lv[i]; end
    for (int i = 0; i < l; i++) begin q_bits.push_back(data[i]); p ^= data[i]; end
    if (PAR == 1) q_bits.push_back(p);
  endtask

  // Wait (bounded) for the next grant and compare with the scoreboard.
  task automatic wait_grant();
    logic [3:0] exp;
    int         cyc;
    exp = (q_grant.size() != 0) ? q_grant.pop_front() : 4'b0000;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (grant == '0 && cyc < 8);
    check("grant", grant, exp);
    check("grant_latency", cyc, 1);
    check("busy_arb", busy, 1);
  endtask

  // Compare n frame bits; on the start bit also check cur_ch and optionally
  // withdraw the request and scramble that requester's inputs.
  task automatic drain(input int n, input int ch, input int glitch, input bit drop);
    logic exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp = (q_bits.size() != 0) ? q_bits.pop_front() : 1'bx;
      check("ser_bit", ser_out, exp);
      if (i == 0) begin
        check("cur_ch", cur_ch, ch);
        if (drop) begin
          req[ch] = 1'b0;
          set_slot(ch, int'($urandom_range(15)), 16'($urandom));
        end
      end
      tx_done = (i == glitch);
    end
  endtask

  // Enter WAIT_DONE, return tx_done after done_dly cycles, expect IDLE next.
  task automatic finish_frame(input int done_dly);
    @(negedge clk);
    tx_done = 1'b0;
    check("wait_level", ser_out, 1);
    check("busy_wait", busy, 1);
    repeat (done_dly) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("busy_after_done", busy, 0);
    check("timeout_quiet", timeout, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int  n;
    bit  early;
    int  order[5];

    vecs[0] = '{2, 5,  16'h0013, 2, -1, 4'b0100};  // basic frame
    vecs[1] = '{1, 0,  16'h0000, 0, -1, 4'b0010};  // zero length
    vecs[2] = '{0, 15, 16'hA5C3, 5,  4, 4'b0001};  // max length, stray tx_done in LEN
    vecs[3] = '{3, 1,  16'hFFFF, 1, -1, 4'b1000};  // single payload bit
    vecs[4] = '{1, 3,  16'h0005, 0, -1, 4'b0010};  // parity example (5 ones)
    vecs[5] = '{3, 4,  16'hFFF6, 3,  9, 4'b1000};  // high data bits ignored, stray tx_done in DATA
    vecs[6] = '{0, 8,  16'h80F1, 1, -1, 4'b0001};

    rst = 1'b0; req = '0; req_len = '0; req_data = '0; tx_done = 1'b0;
    #1;
    check("rst_ser_out", ser_out, 1);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b1;

    // ---- table-driven single frames ----
    foreach (vecs[i]) begin
      @(negedge clk);
      set_slot(vecs[i].ch, vecs[i].len, vecs[i].data);
      req[vecs[i].ch] = 1'b1;
      q_grant.push_back(vecs[i].exp_grant);
      push_frame(vecs[i].ch, vecs[i].len, vecs[i].data);
      wait_grant();
      n = 7 + vecs[i].len + PAR;
      drain(n, vecs[i].ch, vecs[i].glitch, 1'b1);
      finish_frame(vecs[i].done_dly);
    end

    // ---- round-robin with all four requests held ----
    do_reset();
    for (int c = 0; c < NCH; c++) set_slot(c, c + 2, 16'hA5A5 ^ 16'(c * 16'h1111));
    req = 4'b1111;
    order = '{0, 1, 2, 3, 0};
    foreach (order[k]) q_grant.push_back(4'(1 << order[k]));
    foreach (order[k]) begin
      push_frame(order[k], order[k] + 2, 16'hA5A5 ^ 16'(order[k] * 16'h1111));
      wait_grant();
      drain(7 + order[k] + 2 + PAR, order[k], -1, 1'b0);
      finish_frame(2);
    end
    req = '0;

    // ---- timeout, then the pending requester is served ----
    @(negedge clk);
    set_slot(1, 2, 16'h0003);
    req[1] = 1'b1;
    q_grant.push_back(4'b0010);
    push_frame(1, 2, 16'h0003);
    wait_grant();
    drain(7 + 2 + PAR, 1, -1, 1'b1);
    @(negedge clk);  // first WAIT_DONE cycle
    check("to_wait_level", ser_out, 1);
    set_slot(2, 1, 16'h0001);
    req[2] = 1'b1;
    early = 1'b0;
    for (int j = 1; j < TMO; j++) begin
      @(negedge clk);
      if (timeout !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    check("timeout_early", early, 0);
    @(negedge clk);
    check("timeout_pulse", timeout, 1);
    check("busy_after_timeout", busy, 0);
    @(negedge clk);
    check("timeout_width", timeout, 0);
    check("grant_after_timeout", grant, 4'b0100);
    push_frame(2, 1, 16'h0001);
    drain(7 + 1 + PAR, 2, -1, 1'b1);
    finish_frame(0);

    // ---- reset during payload bit 3 of a 10-bit frame ----
    @(negedge clk);
    set_slot(2, 10, 16'h02B5);
    req[2] = 1'b1;
    q_grant.push_back(4'b0100);
    push_frame(2, 10, 16'h02B5);
    wait_grant();
    drain(11, 2, -1, 1'b1);  // last compared bit is payload bit 3 (a 0)
    set_slot(1, 2, 16'h0002);
    set_slot(3, 3, 16'h0007);
    req = 4'b1010;
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ser_out", ser_out, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cur_ch", cur_ch, 0);
    check("rst_mid_grant", grant, 0);
    q_bits.delete();
    @(negedge clk);
    rst = 1'b1;
    q_grant.push_back(4'b0010);  // pointer back at 0: requester 1 before 3
    push_frame(1, 2, 16'h0002);
    wait_grant();
    drain(7 + 2 + PAR, 1, -1, 1'b1);
    finish_frame(1);
    q_grant.push_back(4'b1000);
    push_frame(3, 3, 16'h0007);
    wait_grant();
    drain(7 + 3 + PAR, 3, -1, 1'b1);
    finish_frame(0);

    // ---- request withdrawn during ARB: no grant, pointer unchanged ----
    @(negedge clk);
    set_slot(0, 2, 16'h0001);
    req = 4'b0001;
    @(negedge clk);
    check("arb_grant_live", grant, 4'b0001);
    req = '0;
    #1;
    check("arb_grant_withdrawn", grant, 0);
    @(negedge clk);
    check("arb_drop_busy", busy, 0);
    check("arb_drop_ser_out", ser_out, 1);
    set_slot(3, 1, 16'h0000);
    req = 4'b1001;
    q_grant.push_back(4'b0001);
    push_frame(0, 2, 16'h0001);
    wait_grant();
    drain(7 + 2 + PAR, 0, -1, 1'b1);
    finish_frame(0);
    q_grant.push_back(4'b1000);
    push_frame(3, 1, 16'h0000);
    wait_grant();
    drain(7 + 1 + PAR, 3, -1, 1'b1);
    finish_frame(0);
    req = '0;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
